// File: rtl/multi_clk_gen_pkg.sv
// Shared types and constants for the multi-channel clock/event generator.
// The struct field widths set the widest half-period/offset/limit a channel can hold.
package multi_clk_gen_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_CYC_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ch_state_e;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] half;
    logic [DEF_CNT_W-1:0] offset;
    logic [DEF_CYC_W-1:0] limit;
  } ch_cfg_t;

  localparam ch_cfg_t CFG_RESET = '{half: DEF_CNT_W'(1), offset: '0, limit: '0};

  // A half-period of 0 behaves like 1, so both reload the counter with 0.
  function automatic logic [DEF_CNT_W-1:0] half_reload(input logic [DEF_CNT_W-1:0] half);
    return (half == '0) ? '0 : half - 1'b1;
  endfunction

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_clk_gen_if.sv
// Configuration bus of the clock generator: write strobe, target channel,
// the three config fields and the rejected-write pulse.
interface multi_clk_gen_if #(
  parameter int NUM_CH = multi_clk_gen_pkg::DEF_NUM_CH,
  parameter int CNT_W  = multi_clk_gen_pkg::DEF_CNT_W,
  parameter int CYC_W  = multi_clk_gen_pkg::DEF_CYC_W
);

  localparam int CH_W = multi_clk_gen_pkg::ch_idx_w(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic [CNT_W-1:0] cfg_offset;
  logic [CYC_W-1:0] cfg_limit;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_ch, cfg_half, cfg_offset, cfg_limit,
    input  cfg_err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_half, cfg_offset, cfg_limit,
    output cfg_err
  );

endinterface

// File: rtl/multi_clk_gen_channel.sv
// One generator channel: config registers, IDLE/DELAY/RUN/DONE sequencing,
// the divided clock and its rising-edge counter.
module clk_gen_channel
  import multi_clk_gen_pkg::*;
#(
  parameter int CYC_W = DEF_CYC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  ch_cfg_t          cfg_in,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             qualify,
  output logic             gen_clk,
  output logic             rise,
  output logic [CYC_W-1:0] cyc,
  output logic             done
);

  ch_state_e            state_q, state_d;
  ch_cfg_t              cfg_q, cfg_d;
  logic [DEF_CNT_W-1:0] cnt_q, cnt_d;
  logic                 gen_q, gen_d;
  logic                 rise_q, rise_d;
  logic                 done_q, done_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic                 restartable;

  assign restartable = (state_q == IDLE) || (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= CFG_RESET;
      cnt_q   <= '0;
      gen_q   <= 1'b0;
      rise_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      gen_q   <= gen_d;
      rise_q  <= rise_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end

  // Writes, start and stop act regardless of en; only the timing machinery freezes.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    gen_d   = gen_q;
    rise_d  = 1'b0;
    done_d  = done_q;
    cyc_d   = cyc_q;

    if (wr && restartable) begin
      cfg_d = cfg_in;
    end

    if (stop) begin
      state_d = IDLE;
      gen_d   = 1'b0;
      done_d  = 1'b0;
    end else if (start && restartable) begin
      cyc_d  = '0;
      done_d = 1'b0;
      gen_d  = 1'b0;
      if (cfg_q.offset != '0) begin
        state_d = DELAY;
        cnt_d   = cfg_q.offset - 1'b1;
      end else begin
        state_d = RUN;
        cnt_d   = half_reload(cfg_q.half);
      end
    end else if (en) begin
      case (state_q)
        DELAY: begin
          if (cnt_q == '0) begin
            state_d = RUN;
            cnt_d   = half_reload(cfg_q.half);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            cnt_d = half_reload(cfg_q.half);
            gen_d = ~gen_q;
            if (!gen_q) begin
              rise_d = 1'b1;
              cyc_d  = cyc_q + 1'b1;
              // A zero limit means free-running: the count simply wraps.
              if ((cfg_q.limit != '0) && (cyc_d == CYC_W'(cfg_q.limit))) begin
                done_d  = 1'b1;
                state_d = DONE;
              end
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          gen_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q == DELAY) || (state_q == RUN);
  assign qualify = (state_q != IDLE) && (cfg_q.limit != '0);
  assign gen_clk = gen_q;
  assign rise    = rise_q;
  assign cyc     = cyc_q;
  assign done    = done_q;

endmodule

// File: rtl/multi_clk_gen.sv
// Multi-channel programmable clock/event generator: config decode, write
// rejection and the all-done summary around NUM_CH independent channels.
module multi_clk_gen
  import multi_clk_gen_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int CYC_W  = DEF_CYC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  multi_clk_gen_if.slave          cfg,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  output logic [NUM_CH-1:0]       gen_clk,
  output logic [NUM_CH-1:0]       rise,
  output logic [NUM_CH*CYC_W-1:0] cyc,
  output logic [NUM_CH-1:0]       parity,
  output logic [NUM_CH-1:0]       done,
  output logic                    all_done
);

  logic [CNT_W-1:0]  half_in;
  logic [CNT_W-1:0]  offset_in;
  logic [CYC_W-1:0]  limit_in;
  ch_cfg_t           cfg_word;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] qualify;
  logic              ch_valid;
  logic              err_d;
  logic              err_q;

  assign half_in   = cfg.cfg_half;
  assign offset_in = cfg.cfg_offset;
  assign limit_in  = cfg.cfg_limit;

  // A write is steered to its channel even when that channel is busy; the
  // channel drops it and the busy flag turns it into a cfg_err pulse here.
  always_comb begin
    cfg_word.half   = DEF_CNT_W'(half_in);
    cfg_word.offset = DEF_CNT_W'(offset_in);
    cfg_word.limit  = DEF_CYC_W'(limit_in);
    ch_valid        = (int'(cfg.cfg_ch) < NUM_CH);
    wr_sel          = '0;
    err_d           = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_we && (int'(cfg.cfg_ch) == i)) begin
        wr_sel[i] = 1'b1;
        err_d     = busy[i];
      end
    end
    if (cfg.cfg_we && !ch_valid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg.cfg_err = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gen_channel #(
      .CYC_W (CYC_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .wr      (wr_sel[i]),
      .cfg_in  (cfg_word),
      .start   (start[i]),
      .stop    (stop[i]),
      .busy    (busy[i]),
      .qualify (qualify[i]),
      .gen_clk (gen_clk[i]),
      .rise    (rise[i]),
      .cyc     (cyc[i*CYC_W +: CYC_W]),
      .done    (done[i])
    );
    assign parity[i] = cyc[i*CYC_W];
  end

  // Channels without a limit, or never started, do not take part in all_done.
  always_comb begin
    all_done = (|qualify) && (&(done | ~qualify));
  end

endmodule

// File: tb/tb_multi_clk_gen.sv
// Directed bench for multi_clk_gen with three channels; expected waveforms
// come from the closed-form edge times start + offset + half*(2k-1).
module tb_multi_clk_gen;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int YW  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   stop;
  logic [NCH-1:0]   gen_clk;
  logic [NCH-1:0]   rise;
  logic [NCH*YW-1:0] cyc;
  logic [NCH-1:0]   parity;
  logic [NCH-1:0]   done;
  logic             all_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_clk_gen_if #(.NUM_CH(NCH), .CNT_W(CW), .CYC_W(YW)) cfg_bus ();

  multi_clk_gen #(.NUM_CH(NCH), .CNT_W(CW), .CYC_W(YW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cfg      (cfg_bus),
    .start    (start),
    .stop     (stop),
    .gen_clk  (gen_clk),
    .rise     (rise),
    .cyc      (cyc),
    .parity   (parity),
    .done     (done),
    .all_done (all_done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] ch, input logic [CW-1:0] half,
                               input logic [CW-1:0] off, input logic [YW-1:0] lim,
                               input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    cfg_bus.cfg_we     = we;
    cfg_bus.cfg_ch     = ch;
    cfg_bus.cfg_half   = half;
    cfg_bus.cfg_offset = off;
    cfg_bus.cfg_limit  = lim;
    start              = st;
    stop               = sp;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [YW-1:0] cycOf(input int ch);
    return cyc[ch*YW +: YW];
  endfunction

  // Reference waveforms r edges after the start edge, ignoring limits.
  function automatic bit hiAt(input int r, input int h, input int o);
    return (r >= o + h) && (((r - o - h) % (2 * h)) < h);
  endfunction

  function automatic bit riseAt(input int r, input int h, input int o);
    return (r >= o + h) && (((r - o - h) % (2 * h)) == 0);
  endfunction

  function automatic int cntAt(input int r, input int h, input int o, input int lim);
    int n;
    n = (r < o + h) ? 0 : (r - o - h) / (2 * h) + 1;
    if (lim != 0 && n > lim) n = lim;
    return n;
  endfunction

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_gen",      gen_clk,  0);
    checkOutput("rst_rise",     rise,     0);
    checkOutput("rst_cyc",      cyc,      0);
    checkOutput("rst_done",     done,     0);
    checkOutput("rst_cfg_err",  cfg_bus.cfg_err, 0);
    checkOutput("rst_all_done", all_done, 0);
    rst_n = 1'b1;
    tick();

    applyStimulus(1, 0, 10, 5, 21, 0, 0);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("cfg_idle_no_err", cfg_bus.cfg_err, 0);
    applyStimulus(0, 0, 0, 0, 0, 3'b011, 0);
    tick();
    checkOutput("start_gen", gen_clk, 0);

    // ch0 (half 10, offset 5, limit 21) and ch1 (half 0, free) from edge T
    for (int rel = 1; rel <= 430; rel++) begin
      if (rel == 50)      applyStimulus(1, 0, 3, 0, 5, 0, 0);
      else if (rel == 60) applyStimulus(1, 3, 4, 4, 4, 0, 0);
      else if (rel == 70) applyStimulus(1, 2, 2, 0, 0, 0, 0);
      else                applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput($sformatf("gen0@%0d", rel),  gen_clk[0], hiAt(rel, 10, 5) && rel <= 415);
      checkOutput($sformatf("rise0@%0d", rel), rise[0], riseAt(rel, 10, 5) && rel <= 415);
      checkOutput($sformatf("cyc0@%0d", rel),  cycOf(0), cntAt(rel, 10, 5, 21));
      checkOutput($sformatf("par0@%0d", rel),  parity[0], cntAt(rel, 10, 5, 21) % 2);
      checkOutput($sformatf("done0@%0d", rel), done[0], rel >= 415);
      checkOutput($sformatf("gen1@%0d", rel),  gen_clk[1], hiAt(rel, 1, 0));
      checkOutput($sformatf("rise1@%0d", rel), rise[1], riseAt(rel, 1, 0));
      checkOutput($sformatf("cyc1@%0d", rel),  cycOf(1), cntAt(rel, 1, 0, 0));
      checkOutput($sformatf("done1@%0d", rel), done[1], 0);
      checkOutput($sformatf("gen2@%0d", rel),  gen_clk[2], 0);
      checkOutput($sformatf("cfg_err@%0d", rel), cfg_bus.cfg_err, rel == 50 || rel == 60);
      checkOutput($sformatf("all_done@%0d", rel), all_done, rel >= 415);
    end

    // ch2 (half 2) started, then start+stop together at edge 7
    applyStimulus(0, 0, 0, 0, 0, 3'b100, 0);
    tick();
    for (int rel = 1; rel <= 10; rel++) begin
      if (rel == 7) applyStimulus(0, 0, 0, 0, 0, 3'b100, 3'b100);
      else          applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput($sformatf("ss_gen2@%0d", rel),  gen_clk[2], (rel < 7) ? hiAt(rel, 2, 0) : 1'b0);
      checkOutput($sformatf("ss_rise2@%0d", rel), rise[2], (rel < 7) ? riseAt(rel, 2, 0) : 1'b0);
      checkOutput($sformatf("ss_cyc2@%0d", rel),  cycOf(2), (rel < 7) ? cntAt(rel, 2, 0, 0) : 2);
      checkOutput($sformatf("ss_done2@%0d", rel), done[2], 0);
      checkOutput($sformatf("ss_all_done@%0d", rel), all_done, 1);
    end

    // ch2 restarted; en low for edges 3..9 delays everything after edge 2 by 7
    applyStimulus(0, 0, 0, 0, 0, 3'b100, 0);
    tick();
    for (int rel = 1; rel <= 20; rel++) begin
      int eff;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      en  = !(rel >= 3 && rel <= 9);
      eff = (rel <= 2) ? rel : (rel <= 9) ? 2 : rel - 7;
      tick();
      checkOutput($sformatf("en_gen2@%0d", rel),  gen_clk[2], hiAt(eff, 2, 0));
      checkOutput($sformatf("en_rise2@%0d", rel), rise[2], (rel <= 2 || rel >= 10) && riseAt(eff, 2, 0));
      checkOutput($sformatf("en_cyc2@%0d", rel),  cycOf(2), cntAt(eff, 2, 0, 0));
    end
    en = 1'b1;

    // Asynchronous reset between clock edges
    checkOutput("pre_rst_done0", done[0], 1);
    checkOutput("pre_rst_cyc1_nz", cycOf(1) != 0, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_gen",      gen_clk,  0);
    checkOutput("arst_rise",     rise,     0);
    checkOutput("arst_cyc",      cyc,      0);
    checkOutput("arst_parity",   parity,   0);
    checkOutput("arst_done",     done,     0);
    checkOutput("arst_all_done", all_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    checkOutput("post_rst_gen",  gen_clk, 0);
    checkOutput("post_rst_cyc",  cyc,     0);
    checkOutput("post_rst_done", done,    0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
